snoop_mux_ot: RTL

//  Multiplexes NoSlvPorts ACE snoop slave ports (AC out, CR/CD back) onto one master port, allowing
//  up to MaxTrans snoops in flight instead of one. Sits between the CCU snoop fan-out and a cache's

---
 rtl/snoop_mux_ot.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/snoop_mux_ot.sv
// ACE snoop multiplexer: NoSlvPorts snoop slave ports onto one master port with up to MaxTrans snoops in flight.
// Define SNOOP_MUX_OT_PERF_EN to expose inflight_o and enable the embedded SVA checks.

typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  snoop;
    logic [2:0]  prot;
} snoop_mux_ot_ac_t;

typedef logic [4:0] snoop_mux_ot_cr_t;

typedef struct packed {
    logic [31:0] data;
    logic        last;
} snoop_mux_ot_cd_t;

typedef struct packed {
    logic             ac_valid;
    snoop_mux_ot_ac_t ac;
    logic             cr_ready;
    logic             cd_ready;
} snoop_mux_ot_req_t;

typedef struct packed {
    logic             ac_ready;
    logic             cr_valid;
    snoop_mux_ot_cr_t cr_resp;
    logic             cd_valid;
    snoop_mux_ot_cd_t cd;
} snoop_mux_ot_resp_t;

module snoop_mux_ot_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned W     = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    mem_q [Depth];

    // Pointers wrap explicitly so Depth need not be a power of two.
    function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        wr_d  = push_i ? wrap_inc(wr_q) : wr_q;
        rd_d  = pop_i  ? wrap_inc(rd_q) : rd_q;
        cnt_d = cnt_q + CntW'(push_i) - CntW'(pop_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CntW'(Depth));

`ifdef SNOOP_MUX_OT_PERF_EN
    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && empty_o));
`endif
endmodule

module snoop_mux_ot #(
    parameter type         ac_chan_t    = snoop_mux_ot_ac_t,
    parameter type         cr_chan_t    = snoop_mux_ot_cr_t,
    parameter type         cd_chan_t    = snoop_mux_ot_cd_t,
    parameter type         snoop_req_t  = snoop_mux_ot_req_t,
    parameter type         snoop_resp_t = snoop_mux_ot_resp_t,
    parameter int unsigned NoSlvPorts   = 2,
    parameter int unsigned MaxTrans     = 4,
    parameter bit          SpillAc      = 1'b1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  snoop_req_t  [NoSlvPorts-1:0]  slv_reqs_i,
    output snoop_resp_t [NoSlvPorts-1:0]  slv_resps_o,
    output snoop_req_t                    mst_req_o,
    input  snoop_resp_t                   mst_resp_i
`ifdef SNOOP_MUX_OT_PERF_EN
    ,
    output logic [$clog2(MaxTrans+1)-1:0] inflight_o
`endif
);
    localparam int unsigned IdxW = $clog2(NoSlvPorts);
    localparam int unsigned CntW = $clog2(MaxTrans + 1);

    logic [IdxW-1:0] rr_q, rr_d, lock_idx_q, lock_idx_d, sel;
    logic            lock_q, lock_d, active_q, active_d, sel_found;
    logic            ac_block, arb_valid, arb_ready, arb_hs, mst_ac_valid;
    ac_chan_t        mst_ac;
    logic            cr_empty, cr_full, cd_empty, cd_full;
    logic [IdxW-1:0] cr_head, cd_head;
    logic            cr_dt, cr_stall, mst_cr_ready, mst_cd_ready, cr_hs, cd_hs;
    logic [CntW-1:0] cnt_q, cnt_d;
    cr_chan_t        mst_cr;
    cd_chan_t        mst_cd;

    assign mst_cr = mst_resp_i.cr_resp;
    assign mst_cd = mst_resp_i.cd;

    // Round-robin pick; a presented-but-unaccepted request stays locked until its handshake.
    always_comb begin
        sel       = lock_idx_q;
        sel_found = 1'b0;
        if (lock_q) begin
            sel_found = slv_reqs_i[lock_idx_q].ac_valid;
        end else begin
            for (int k = NoSlvPorts - 1; k >= 0; k--) begin
                if (slv_reqs_i[(int'(rr_q) + k) % NoSlvPorts].ac_valid) begin
                    sel       = IdxW'((int'(rr_q) + k) % NoSlvPorts);
                    sel_found = 1'b1;
                end
            end
        end
    end

    // Both block terms come from registered state, so a retire frees a slot only on the next cycle.
    assign ac_block  = (cnt_q == CntW'(MaxTrans)) || cr_full;
    assign arb_valid = sel_found && !ac_block && active_q;
    assign arb_hs    = arb_valid && arb_ready;

    always_comb begin
        active_d   = 1'b1;
        lock_d     = arb_valid && !arb_hs;
        lock_idx_d = lock_d ? sel : lock_idx_q;
        rr_d       = rr_q;
        if (arb_hs) rr_d = (sel == IdxW'(NoSlvPorts - 1)) ? '0 : sel + IdxW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active_q   <= 1'b0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            rr_q       <= '0;
            cnt_q      <= '0;
        end else begin
            active_q   <= active_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
        end
    end

    if (SpillAc) begin : g_spill
        logic     vld_q, vld_d;
        ac_chan_t ac_q, ac_d;

        always_comb begin
            vld_d = vld_q;
            ac_d  = ac_q;
            if (vld_q && mst_resp_i.ac_ready) vld_d = 1'b0;
            if (arb_hs) begin
                vld_d = 1'b1;
                ac_d  = slv_reqs_i[sel].ac;
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                vld_q <= 1'b0;
                ac_q  <= '0;
            end else begin
                vld_q <= vld_d;
                ac_q  <= ac_d;
            end
        end

        assign arb_ready    = !vld_q || mst_resp_i.ac_ready;
        assign mst_ac_valid = vld_q;
        assign mst_ac       = vld_q ? ac_q : '0;
    end else begin : g_bypass
        assign arb_ready    = mst_resp_i.ac_ready;
        assign mst_ac_valid = arb_valid;
        assign mst_ac       = arb_valid ? slv_reqs_i[sel].ac : '0;
    end

    snoop_mux_ot_fifo #(.Depth(MaxTrans), .W(IdxW)) i_cr_fifo (
        .clk_i, .rst_i, .push_i(arb_hs), .data_i(sel), .pop_i(cr_hs),
        .data_o(cr_head), .empty_o(cr_empty), .full_o(cr_full)
    );

    snoop_mux_ot_fifo #(.Depth(MaxTrans), .W(IdxW)) i_cd_fifo (
        .clk_i, .rst_i, .push_i(cr_hs && cr_dt), .data_i(cr_head), .pop_i(cd_hs && mst_cd.last),
        .data_o(cd_head), .empty_o(cd_empty), .full_o(cd_full)
    );

    // A data-carrying CR needs a cd_fifo slot before it may complete.
    assign cr_dt        = mst_cr[0];
    assign cr_stall     = cr_dt && cd_full;
    assign mst_cr_ready = !cr_empty && slv_reqs_i[cr_head].cr_ready && !cr_stall;
    assign mst_cd_ready = !cd_empty && slv_reqs_i[cd_head].cd_ready;
    assign cr_hs        = mst_resp_i.cr_valid && mst_cr_ready;
    assign cd_hs        = mst_resp_i.cd_valid && mst_cd_ready;

    assign cnt_d = cnt_q + CntW'(arb_hs) - CntW'(cr_hs && !cr_dt) - CntW'(cd_hs && mst_cd.last);

    always_comb begin
        mst_req_o          = '0;
        mst_req_o.ac_valid = mst_ac_valid;
        mst_req_o.ac       = mst_ac;
        mst_req_o.cr_ready = mst_cr_ready;
        mst_req_o.cd_ready = mst_cd_ready;
        for (int i = 0; i < NoSlvPorts; i++) begin
            slv_resps_o[i]          = '0;
            slv_resps_o[i].ac_ready = arb_hs && (sel == IdxW'(i));
            if (!cr_empty && (cr_head == IdxW'(i)) && !cr_stall) begin
                slv_resps_o[i].cr_valid = mst_resp_i.cr_valid;
                slv_resps_o[i].cr_resp  = mst_resp_i.cr_valid ? mst_cr : '0;
            end
            if (!cd_empty && (cd_head == IdxW'(i))) begin
                slv_resps_o[i].cd_valid = mst_resp_i.cd_valid;
                slv_resps_o[i].cd       = mst_resp_i.cd_valid ? mst_cd : '0;
            end
        end
    end

`ifdef SNOOP_MUX_OT_PERF_EN
    assign inflight_o = cnt_q;
    a_cd_route: assert property (@(posedge clk_i) disable iff (rst_i) !(mst_req_o.cd_ready && cd_empty));
    a_cnt_max:  assert property (@(posedge clk_i) disable iff (rst_i) cnt_q <= CntW'(MaxTrans));
`endif
endmodule
